// File: rtl/eth_crc_pkg.sv
// eth_crc_pkg
//   Shared constants and types for the RX FCS checker:
//   - CRC-32 polynomial, initial value and good-frame residue
//   - controller state enum and the tail byte-count type
//   - helpers: bit reflection for the polynomial, byte count from keep
package eth_crc_pkg;

  localparam int CRC_WIDTH = 32;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  // Bytes in a 32-bit beat, 0..4.
  typedef logic [2:0] byte_cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2
  } crc_ctrl_state_e;

  // The wire order is LSB first, so the datapath shifts right and uses the
  // bit-reversed polynomial.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // Byte count of a last beat: index of the highest set enable + 1. For a
  // contiguous mask this equals the popcount; a stray hole below the top bit
  // does not shorten the frame.
  function automatic byte_cnt_t keep_count(input logic [3:0] keep);
    byte_cnt_t cnt;
    cnt = '0;
    for (int i = 0; i < 4; i++) begin
      if (keep[i]) begin
        cnt = byte_cnt_t'(i + 1);
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/crc_step.sv
// crc_step
//   Combinational reflected CRC-32 next-state function over DATA_W bits,
//   data bit 0 consumed first.
//   Ports:
//     crc_in   current CRC register value
//     data_in  DATA_W bits to fold in
//     crc_out  CRC register value after folding in data_in
module crc_step
  import eth_crc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [CRC_WIDTH-1:0] crc_in,
  input  logic [DATA_W-1:0]    data_in,
  output logic [CRC_WIDTH-1:0] crc_out
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

  logic [CRC_WIDTH-1:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < DATA_W; i++) begin
      if (c[0] ^ data_in[i]) begin
        c = (c >> 1) ^ POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_rx_fcs_ctrl.sv
// eth_rx_fcs_ctrl
//   Runs the CRC-32 over an incoming Ethernet frame (32-bit beats, FCS
//   included) and pulses pass/fail once per frame. Full beats take one
//   cycle; a 1-3 byte last beat is folded one byte per cycle while the
//   upstream is stalled.
//   Ports:
//     clk, nreset   clock, asynchronous active-low reset
//     valid_i       beat valid
//     ready_o       beat accepted when valid_i && ready_o
//     start_i       first beat of a frame
//     last_i        final beat of a frame
//     keep_i        byte enables of the last beat (ignored otherwise)
//     data_i        beat data, byte 0 in bits 7:0 (first on the wire)
//     crc_ok_o      one-cycle pulse, FCS correct
//     crc_err_o     one-cycle pulse, FCS wrong
//     busy_o        frame in progress (RUN or TAIL)
//     drop_o        one-cycle pulse, beat without start_i discarded in IDLE
//     crc_o         ~crc_q, running FCS value
//
//   Handshake: a beat transfers on a rising edge where valid_i && ready_o.
//   ready_o depends only on state (low in TAIL), never on valid_i, so the
//   source may hold valid_i and its payload until the transfer happens.
module eth_rx_fcs_ctrl
  import eth_crc_pkg::*;
#(
  parameter int DATA_W = 32,          // only 32 is supported
  parameter int KEEP_W = DATA_W / 8,
  parameter int CRC_W  = 32
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              start_i,
  input  logic              last_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              crc_ok_o,
  output logic              crc_err_o,
  output logic              busy_o,
  output logic              drop_o,
  output logic [CRC_W-1:0]  crc_o
);

  crc_ctrl_state_e      state_q, state_d;
  logic [CRC_W-1:0]     crc_q, crc_d;
  logic [DATA_W-1:0]    tail_data_q, tail_data_d;
  byte_cnt_t            tail_cnt_q, tail_cnt_d;
  logic                 crc_ok_q, crc_err_q, drop_q;
  logic                 drop_d;
  logic                 publish;
  logic [CRC_W-1:0]     pub_crc;

  logic                 accept;
  logic [CRC_W-1:0]     src_crc;
  logic [CRC_W-1:0]     beat_crc;
  logic [CRC_W-1:0]     byte_crc;
  byte_cnt_t            last_cnt;

  assign accept   = valid_i && ready_o;
  // A start beat always restarts from INIT, which also silently abandons
  // any frame that was still in RUN.
  assign src_crc  = start_i ? CRC_INIT : crc_q;
  assign last_cnt = keep_count(keep_i);

  crc_step #(.DATA_W(DATA_W)) u_step_beat (
    .crc_in  (src_crc),
    .data_in (data_i),
    .crc_out (beat_crc)
  );

  // TAIL bytes are consumed from the bottom of the latched beat, which is
  // shifted down one byte per cycle.
  crc_step #(.DATA_W(8)) u_step_byte (
    .crc_in  (crc_q),
    .data_in (tail_data_q[7:0]),
    .crc_out (byte_crc)
  );

  assign ready_o = (state_q != TAIL);
  assign busy_o  = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    tail_data_d = tail_data_q;
    tail_cnt_d  = tail_cnt_q;
    drop_d      = 1'b0;
    publish     = 1'b0;
    pub_crc     = beat_crc;

    case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          if ((state_q == IDLE) && !start_i) begin
            drop_d = 1'b1;
          end else if (!last_i) begin
            crc_d   = beat_crc;
            state_d = RUN;
          end else if (last_cnt == byte_cnt_t'(4)) begin
            crc_d   = beat_crc;
            publish = 1'b1;
            pub_crc = beat_crc;
            state_d = IDLE;
          end else if (last_cnt == byte_cnt_t'(0)) begin
            crc_d   = src_crc;
            publish = 1'b1;
            pub_crc = src_crc;
            state_d = IDLE;
          end else begin
            // Park the source state in crc_q; TAIL folds bytes into it.
            crc_d       = src_crc;
            tail_data_d = data_i;
            tail_cnt_d  = last_cnt;
            state_d     = TAIL;
          end
        end
      end
      TAIL: begin
        crc_d       = byte_crc;
        tail_data_d = tail_data_q >> 8;
        tail_cnt_d  = tail_cnt_q - byte_cnt_t'(1);
        if (tail_cnt_q == byte_cnt_t'(1)) begin
          publish = 1'b1;
          pub_crc = byte_crc;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      crc_q       <= CRC_INIT;
      tail_data_q <= '0;
      tail_cnt_q  <= '0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      tail_data_q <= tail_data_d;
      tail_cnt_q  <= tail_cnt_d;
      crc_ok_q    <= publish && (pub_crc == CRC_RESIDUE);
      crc_err_q   <= publish && (pub_crc != CRC_RESIDUE);
      drop_q      <= drop_d;
    end
  end

  assign crc_ok_o  = crc_ok_q;
  assign crc_err_o = crc_err_q;
  assign drop_o    = drop_q;
  assign crc_o     = ~crc_q;

endmodule

// File: tb/tb_eth_rx_fcs_ctrl.sv
// tb_eth_rx_fcs_ctrl
//   Bench for eth_rx_fcs_ctrl: reset values, a table of single-beat
//   responses, hand-written tail/abandon/reset sequences and randomized
//   frames checked against a byte-level CRC-32 frame model.
module tb_eth_rx_fcs_ctrl;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic        start;
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
    logic        exp_ok;
    logic        exp_err;
    logic        exp_drop;
    logic        exp_busy;
    logic [31:0] exp_crc;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        nreset;
  logic        valid_i, start_i, last_i;
  logic [3:0]  keep_i;
  logic [31:0] data_i;
  logic        ready_o, crc_ok_o, crc_err_o, busy_o, drop_o;
  logic [31:0] crc_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  eth_rx_fcs_ctrl #(.DATA_W(32), .KEEP_W(4), .CRC_W(32)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .start_i   (start_i),
    .last_i    (last_i),
    .keep_i    (keep_i),
    .data_i    (data_i),
    .crc_ok_o  (crc_ok_o),
    .crc_err_o (crc_err_o),
    .busy_o    (busy_o),
    .drop_o    (drop_o),
    .crc_o     (crc_o)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] crc_tab[256];

  function automatic logic [31:0] crc32(input byte_q_t q);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) c = crc_tab[(c ^ {24'h0, q[i]}) & 32'hFF] ^ (c >> 8);
    return ~c;
  endfunction

  function automatic byte_q_t add_fcs(input byte_q_t payload);
    byte_q_t f;
    logic [31:0] fcs;
    f = payload;
    fcs = crc32(payload);
    for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
    return f;
  endfunction

  // A frame is good when its trailing 4 bytes (LSB first) are the CRC-32 of
  // everything before them.
  function automatic logic model_ok(input byte_q_t f);
    byte_q_t p;
    logic [31:0] fcs;
    p = f;
    fcs = '0;
    for (int i = 3; i >= 0; i--) fcs[8*i +: 8] = p.pop_back();
    return crc32(p) == fcs;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [1:0] exp_q[$];   // {ok, err}
  logic       sb_en = 1'b0;
  int         ready_low = 0, ok_cnt = 0, err_cnt = 0, drop_cnt = 0;
  int         last_pulse_cyc = -1;
  logic       last_pulse_ok = 1'b0;

  always @(negedge clk) begin
    if (nreset) begin
      if (!ready_o) ready_low++;
      if (drop_o) drop_cnt++;
      if (crc_ok_o || crc_err_o) begin
        if (crc_ok_o) ok_cnt++;
        if (crc_err_o) err_cnt++;
        last_pulse_cyc = cyc;
        last_pulse_ok  = crc_ok_o;
        if (crc_ok_o && crc_err_o) check("ok_err_exclusive", 32'd1, 32'd0);
        if (sb_en) begin
          if (exp_q.size() == 0) check("sb_unexpected_pulse", {30'd0, crc_ok_o, crc_err_o}, 32'd0);
          else check("sb_result", {30'd0, crc_ok_o, crc_err_o}, {30'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic s, input logic l, input logic [3:0] k,
                           input logic [31:0] d, output int acc);
    start_i = s; last_i = l; keep_i = k; data_i = d; valid_i = 1'b1;
    acc = -1;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (ready_o) begin
        acc = cyc;
        @(posedge clk);
        #1;
        break;
      end
    end
    if (acc < 0) check("beat_accept_timeout", 32'd0, 32'd1);
    valid_i = 1'b0; start_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t f, input bit noncontig,
                            output int acc_last, output int tail_n);
    int nb, cnt, acc;
    logic [31:0] word;
    logic [3:0]  keep, low;
    nb = (f.size() + 3) / 4;
    tail_n = 0;
    acc_last = -1;
    for (int b = 0; b < nb; b++) begin
      word = $urandom;   // unused byte lanes carry garbage
      cnt = 0;
      for (int j = 0; j < 4; j++) begin
        if (4*b + j < f.size()) begin
          word[8*j +: 8] = f[4*b + j];
          cnt++;
        end
      end
      keep = 4'hF;
      if (b == nb - 1) begin
        keep = '0;
        for (int j = 0; j < cnt; j++) keep[j] = 1'b1;
        if (noncontig && cnt >= 2) begin
          low = 4'($urandom) & ~(4'hF << (cnt - 1));
          keep = (4'h1 << (cnt - 1)) | low;
        end
        tail_n = (cnt == 4) ? 0 : cnt;
      end
      send_beat(b == 0, b == nb - 1, keep, word, acc);
      acc_last = acc;
    end
  endtask

  // Sends one frame and checks stall length, pulse timing and verdict.
  task automatic run_frame_check(input string name, input byte_q_t f, input logic exp_ok);
    int acc, tn, ok0, err0;
    ok0 = ok_cnt; err0 = err_cnt; ready_low = 0;
    send_frame(f, 1'b0, acc, tn);
    repeat (tn + 3) @(negedge clk);
    #1;
    check({name, "_ready_low"}, ready_low, tn);
    check({name, "_pulses"}, (ok_cnt - ok0) + (err_cnt - err0), 1);
    check({name, "_ok"}, ok_cnt - ok0, {31'd0, exp_ok});
    check({name, "_pulse_cyc"}, last_pulse_cyc, acc + tn + 1);
  endtask

  // ---------------- test ----------------
  vec_t    vt[7];
  byte_q_t f, p;
  int      acc, tn, ok0, err0, exp_drop, drop0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = i;
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end

    nreset = 1'b0; valid_i = 0; start_i = 0; last_i = 0; keep_i = 0; data_i = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_crc_o", crc_o, 0);
    check("rst_ok", crc_ok_o, 0);
    check("rst_err", crc_err_o, 0);
    check("rst_drop", drop_o, 0);
    @(negedge clk) nreset = 1'b1;

    // Table: beats whose response is visible the cycle after acceptance.
    //          start last keep   data          ok err drop busy crc_o
    vt[0] = '{1'b0, 1'b0, 4'hF, 32'hA5A5A5A5, 0, 0, 1, 0, 32'h00000000};
    vt[1] = '{1'b1, 1'b0, 4'hF, 32'h00000000, 0, 0, 0, 1, 32'h2144DF1C};
    vt[2] = '{1'b0, 1'b1, 4'hF, 32'h2144DF1C, 1, 0, 0, 0, 32'h2144DF1C};
    vt[3] = '{1'b1, 1'b1, 4'h0, 32'hDEADBEEF, 0, 1, 0, 0, 32'h00000000};
    vt[4] = '{1'b1, 1'b0, 4'h3, 32'h00000000, 0, 0, 0, 1, 32'h2144DF1C};
    vt[5] = '{1'b0, 1'b1, 4'h0, 32'h12345678, 1, 0, 0, 0, 32'h2144DF1C};
    vt[6] = '{1'b0, 1'b0, 4'hF, 32'h00000000, 0, 0, 1, 0, 32'h2144DF1C};
    ready_low = 0;
    for (int i = 0; i < 7; i++) begin
      send_beat(vt[i].start, vt[i].last, vt[i].keep, vt[i].data, acc);
      check($sformatf("vec%0d_ok", i), crc_ok_o, vt[i].exp_ok);
      check($sformatf("vec%0d_err", i), crc_err_o, vt[i].exp_err);
      check($sformatf("vec%0d_drop", i), drop_o, vt[i].exp_drop);
      check($sformatf("vec%0d_busy", i), busy_o, vt[i].exp_busy);
      check($sformatf("vec%0d_crc", i), crc_o, vt[i].exp_crc);
    end
    check("vec_ready_never_low", ready_low, 0);

    // "123456789" + FCS, 1-byte last beat.
    f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
          8'h26, 8'h39, 8'hF4, 8'hCB};
    run_frame_check("chk9", f, 1'b1);
    f[4] = f[4] ^ 8'h10;
    run_frame_check("chk9_flip", f, 1'b0);

    // 7-byte payload + FCS -> 3-byte last beat.
    p = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
    run_frame_check("tail3", add_fcs(p), 1'b1);

    // Abandoned frame, then a zero-payload frame.
    ok0 = ok_cnt; err0 = err_cnt;
    send_beat(1'b1, 1'b0, 4'hF, $urandom, acc);
    send_beat(1'b0, 1'b0, 4'hF, $urandom, acc);
    p = {};
    run_frame_check("abandon", add_fcs(p), 1'b1);
    check("abandon_total_ok", ok_cnt - ok0, 1);
    check("abandon_total_err", err_cnt - err0, 0);

    // Reset while in TAIL.
    p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    ok0 = ok_cnt; err0 = err_cnt;
    send_frame(add_fcs(p), 1'b0, acc, tn);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    check("tailrst_ready", ready_o, 1);
    check("tailrst_busy", busy_o, 0);
    check("tailrst_crc_o", crc_o, 0);
    check("tailrst_okerr", {crc_ok_o, crc_err_o, drop_o}, 0);
    repeat (4) @(negedge clk);
    nreset = 1'b1;
    repeat (3) @(negedge clk);
    check("tailrst_no_pulse", (ok_cnt - ok0) + (err_cnt - err0), 0);
    run_frame_check("after_rst", add_fcs(p), 1'b1);

    // Randomized frames against the model.
    sb_en = 1'b1;
    exp_drop = 0;
    drop0 = drop_cnt;
    for (int it = 0; it < 60; it++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      if ($urandom_range(0, 9) == 0) begin
        send_beat(1'b0, $urandom_range(0, 1), 4'($urandom), $urandom, acc);
        exp_drop++;
      end
      if ($urandom_range(0, 6) == 0) begin
        send_beat(1'b1, 1'b0, 4'hF, $urandom, acc);
      end
      p = {};
      repeat ($urandom_range(0, 18)) p.push_back(8'($urandom));
      f = add_fcs(p);
      if ($urandom_range(0, 2) == 0) begin
        int bi;
        bi = $urandom_range(0, f.size() - 1);
        f[bi] = f[bi] ^ (8'h01 << $urandom_range(0, 7));
      end
      exp_q.push_back(model_ok(f) ? 2'b10 : 2'b01);
      send_frame(f, $urandom_range(0, 1), acc, tn);
    end
    repeat (10) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("rand_drops", drop_cnt - drop0, exp_drop);
    sb_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
